// File: rtl/nf10_axis_upsizer_64_256_if.sv
// AXI4-Stream bundle with NetFPGA tuser metadata; width set per instance.
interface nf10_axis_upsizer_64_256_if #(
  parameter int DATA_WIDTH  = 64,
  parameter int TUSER_WIDTH = 128
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0]  tdata;
  logic [STRB_WIDTH-1:0]  tstrb;
  logic [TUSER_WIDTH-1:0] tuser;
  logic                   tvalid;
  logic                   tready;
  logic                   tlast;

  modport master (
    output tdata, tstrb, tuser, tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tstrb, tuser, tvalid, tlast,
    output tready
  );
endinterface

// File: rtl/nf10_axis_upsizer_64_256.sv
// Packs 64-bit AXI4-Stream beats into 256-bit words, little-endian lane order.
// The output register doubles as the assembly buffer; tvalid rises only on a complete word.
module nf10_axis_upsizer_64_256 #(
  parameter int C_S_AXIS_DATA_WIDTH  = 64,
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_M_AXIS_TUSER_WIDTH = 128
) (
  input  logic                             axi_aclk,
  input  logic                             axi_resetn,
  nf10_axis_upsizer_64_256_if.slave        s_axis,
  nf10_axis_upsizer_64_256_if.master       m_axis
);

  localparam int RATIO  = C_M_AXIS_DATA_WIDTH / C_S_AXIS_DATA_WIDTH;
  localparam int IDX_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int S_STRB = C_S_AXIS_DATA_WIDTH / 8;
  localparam int M_STRB = C_M_AXIS_DATA_WIDTH / 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  logic [IDX_W-1:0]                idx_q;
  logic                            first_beat_q;
  logic [C_M_AXIS_DATA_WIDTH-1:0]  data_q;
  logic [M_STRB-1:0]               strb_q;
  logic [C_M_AXIS_TUSER_WIDTH-1:0] user_q;
  logic                            valid_q;
  logic                            last_q;

  logic [C_M_AXIS_DATA_WIDTH-1:0]  data_nxt;
  logic [M_STRB-1:0]               strb_nxt;
  logic                            s_ready;
  logic                            beat_accept;
  logic                            word_done;

  assign s_ready     = !valid_q || m_axis.tready;
  assign beat_accept = s_axis.tvalid && s_ready;
  assign word_done   = beat_accept && ((idx_q == LAST_IDX) || s_axis.tlast);

  assign s_axis.tready = s_ready;
  assign m_axis.tdata  = data_q;
  assign m_axis.tstrb  = strb_q;
  assign m_axis.tuser  = user_q;
  assign m_axis.tvalid = valid_q;
  assign m_axis.tlast  = last_q;

  // Lane 0 starts a fresh word, so stale upper lanes are wiped for short tails.
  always_comb begin
    data_nxt = data_q;
    strb_nxt = strb_q;
    if (beat_accept) begin
      if (idx_q == '0) begin
        data_nxt = '0;
        strb_nxt = '0;
      end
      for (int l = 0; l < RATIO; l++) begin
        if (idx_q == IDX_W'(l)) begin
          data_nxt[l*C_S_AXIS_DATA_WIDTH +: C_S_AXIS_DATA_WIDTH] = s_axis.tdata;
          strb_nxt[l*S_STRB +: S_STRB]                         = s_axis.tstrb;
        end
      end
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      idx_q        <= '0;
      first_beat_q <= 1'b1;
      data_q       <= '0;
      strb_q       <= '0;
      user_q       <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      data_q  <= data_nxt;
      strb_q  <= strb_nxt;
      valid_q <= word_done || (valid_q && !m_axis.tready);
      if (beat_accept) begin
        if (first_beat_q) begin
          user_q       <= s_axis.tuser;
          first_beat_q <= 1'b0;
        end
        if (word_done) begin
          last_q <= s_axis.tlast;
          idx_q  <= '0;
          // Re-arm after the metadata capture above so a one-beat packet ends ready for the next.
          if (s_axis.tlast) begin
            first_beat_q <= 1'b1;
          end
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_nf10_axis_upsizer_64_256.sv
// Self-checking bench: queue-based packing model compared every cycle, plus directed literal checks.
module tb_nf10_axis_upsizer_64_256;

  localparam int RATIO = 4;

  typedef struct {
    logic [255:0] data;
    logic [31:0]  strb;
    logic [127:0] user;
    logic         last;
  } word_t;

  logic axi_aclk;
  logic axi_resetn;

  nf10_axis_upsizer_64_256_if #(.DATA_WIDTH(64),  .TUSER_WIDTH(128)) s_if ();
  nf10_axis_upsizer_64_256_if #(.DATA_WIDTH(256), .TUSER_WIDTH(128)) m_if ();

  nf10_axis_upsizer_64_256 dut (
    .axi_aclk   (axi_aclk),
    .axi_resetn (axi_resetn),
    .s_axis     (s_if),
    .m_axis     (m_if)
  );

  int n_compared   = 0;
  int n_mismatched = 0;
  int ready_mode   = 0;

  word_t        exp_q[$];
  word_t        out_log[$];
  logic [63:0]  part_data[$];
  logic [7:0]   part_strb[$];
  logic [127:0] pkt_user;
  bit           in_pkt;

  initial begin
    axi_aclk = 1'b0;
    forever #5 axi_aclk = ~axi_aclk;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic void checkOutput(string name, logic [255:0] act, logic [255:0] req);
    n_compared++;
    if (act !== req) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, req);
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    part_data.delete();
    part_strb.delete();
    in_pkt = 1'b0;
  endfunction

  // Gather beats of the current packet; a full group or tlast becomes one expected word.
  function automatic void model_beat(logic [63:0] d, logic [7:0] s, logic [127:0] u, logic l);
    word_t w;
    if (!in_pkt) begin
      pkt_user = u;
      in_pkt   = 1'b1;
    end
    part_data.push_back(d);
    part_strb.push_back(s);
    if (part_data.size() == RATIO || l) begin
      w.data = '0;
      w.strb = '0;
      foreach (part_data[i]) begin
        w.data[i*64 +: 64] = part_data[i];
        w.strb[i*8 +: 8]   = part_strb[i];
      end
      w.user = pkt_user;
      w.last = l;
      exp_q.push_back(w);
      part_data.delete();
      part_strb.delete();
      if (l) in_pkt = 1'b0;
    end
  endfunction

  always @(negedge axi_aclk) begin
    word_t act;
    bit    exp_valid;
    bit    s_ready_exp;
    if (!axi_resetn) begin
      model_reset();
      checkOutput("rst_tvalid", m_if.tvalid, 0);
      checkOutput("rst_tdata",  m_if.tdata,  0);
      checkOutput("rst_tstrb",  m_if.tstrb,  0);
      checkOutput("rst_tuser",  m_if.tuser,  0);
      checkOutput("rst_tlast",  m_if.tlast,  0);
    end else begin
      exp_valid   = (exp_q.size() != 0);
      s_ready_exp = !exp_valid || m_if.tready;
      checkOutput("s_tready", s_if.tready, s_ready_exp);
      checkOutput("m_tvalid", m_if.tvalid, exp_valid);
      if (exp_valid) begin
        checkOutput("m_tdata", m_if.tdata, exp_q[0].data);
        checkOutput("m_tstrb", m_if.tstrb, exp_q[0].strb);
        checkOutput("m_tuser", m_if.tuser, exp_q[0].user);
        checkOutput("m_tlast", m_if.tlast, exp_q[0].last);
        if (m_if.tready) begin
          act.data = m_if.tdata;
          act.strb = m_if.tstrb;
          act.user = m_if.tuser;
          act.last = m_if.tlast;
          out_log.push_back(act);
          void'(exp_q.pop_front());
        end
      end
      if (s_if.tvalid && s_ready_exp) begin
        model_beat(s_if.tdata, s_if.tstrb, s_if.tuser, s_if.tlast);
      end
    end
  end

  initial begin
    forever begin
      @(posedge axi_aclk);
      #1;
      case (ready_mode)
        0:       m_if.tready = 1'b1;
        1:       m_if.tready = ($urandom_range(0, 3) != 0);
        default: m_if.tready = 1'b0;
      endcase
    end
  end

  // Present one beat and hold it until accepted; returns the number of cycles it took.
  task automatic applyStimulus(input logic [63:0] d, input logic [7:0] st, input logic [127:0] u,
                               input logic l, output int tries);
    bit got;
    s_if.tdata  = d;
    s_if.tstrb  = st;
    s_if.tuser  = u;
    s_if.tlast  = l;
    s_if.tvalid = 1'b1;
    got   = 1'b0;
    tries = 0;
    while (!got && tries < 1000) begin
      @(negedge axi_aclk);
      got = s_if.tready;
      @(posedge axi_aclk);
      #1;
      tries++;
    end
    if (!got) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL accept_timeout: beat %h never accepted", d);
    end
    s_if.tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge axi_aclk);
      #1;
    end
  endtask

  task automatic waitDrain();
    int c = 0;
    while ((exp_q.size() != 0 || m_if.tvalid) && c < 200) begin
      @(posedge axi_aclk);
      #1;
      c++;
    end
    checkOutput("drain_pending", exp_q.size(), 0);
  endtask

  int    t;
  int    base;
  word_t w0, w1;

  initial begin
    axi_resetn  = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tstrb  = '0;
    s_if.tuser  = '0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;
    model_reset();
    repeat (3) @(posedge axi_aclk);
    #1;
    checkOutput("init_tvalid", m_if.tvalid, 0);
    axi_resetn = 1'b1;
    idle(2);

    // 64-byte packet
    base = out_log.size();
    for (int k = 1; k <= 8; k++) applyStimulus(64'(k), 8'hFF, 128'h5, k == 8, t);
    waitDrain();
    checkOutput("p64_words", out_log.size() - base, 2);
    if (out_log.size() >= base + 2) begin
      w0 = out_log[base];
      w1 = out_log[base+1];
      checkOutput("p64_w0_lane0", w0.data[63:0], 64'h1);
      checkOutput("p64_w0_lane3", w0.data[255:192], 64'h4);
      checkOutput("p64_w0_strb", w0.strb, 32'hFFFFFFFF);
      checkOutput("p64_w1_strb", w1.strb, 32'hFFFFFFFF);
      checkOutput("p64_w0_last", w0.last, 0);
      checkOutput("p64_w1_last", w1.last, 1);
      checkOutput("p64_w1_data", w1.data, {64'h8, 64'h7, 64'h6, 64'h5});
    end

    // 60-byte packet
    base = out_log.size();
    for (int k = 1; k <= 8; k++) applyStimulus(64'(k + 16), (k == 8) ? 8'h0F : 8'hFF, 128'h6, k == 8, t);
    waitDrain();
    checkOutput("p60_words", out_log.size() - base, 2);
    if (out_log.size() >= base + 2) begin
      w1 = out_log[base+1];
      checkOutput("p60_w1_strb", w1.strb, 32'h0FFFFFFF);
      checkOutput("p60_w1_last", w1.last, 1);
    end

    // 5-beat packet, tuser only from first beat
    base = out_log.size();
    for (int k = 1; k <= 5; k++) applyStimulus(64'hC0DE_0000 + 64'(k), 8'hFF, (k == 1) ? 128'hA5 : 128'hFF, k == 5, t);
    waitDrain();
    checkOutput("p5_words", out_log.size() - base, 2);
    if (out_log.size() >= base + 2) begin
      w0 = out_log[base];
      w1 = out_log[base+1];
      checkOutput("p5_w0_user", w0.user, 128'hA5);
      checkOutput("p5_w1_user", w1.user, 128'hA5);
      checkOutput("p5_w1_strb", w1.strb, 32'h000000FF);
      checkOutput("p5_w1_upper", w1.data[255:64], 0);
      checkOutput("p5_w1_lane0", w1.data[63:0], 64'hC0DE_0005);
    end

    // Downstream stall with a full word held
    ready_mode  = 2;
    m_if.tready = 1'b0;
    for (int k = 1; k <= 4; k++) applyStimulus(64'(k), 8'hFF, 128'h9, 1'b0, t);
    for (int c = 0; c < 10; c++) begin
      @(negedge axi_aclk);
      checkOutput("hold_s_ready", s_if.tready, 0);
      checkOutput("hold_data", m_if.tdata, {64'h4, 64'h3, 64'h2, 64'h1});
      @(posedge axi_aclk);
      #1;
    end
    ready_mode  = 0;
    m_if.tready = 1'b1;
    applyStimulus(64'h5, 8'hFF, 128'h9, 1'b0, t);
    checkOutput("hold_release_accept_tries", t, 1);
    for (int k = 6; k <= 8; k++) applyStimulus(64'(k), 8'hFF, 128'h9, k == 8, t);
    waitDrain();

    // Back-to-back single-beat packets
    base = out_log.size();
    applyStimulus(64'hAAAA, 8'hFF, 128'h11, 1'b1, t);
    applyStimulus(64'hBBBB, 8'hFF, 128'h22, 1'b1, t);
    waitDrain();
    checkOutput("b2b_words", out_log.size() - base, 2);
    if (out_log.size() >= base + 2) begin
      w0 = out_log[base];
      w1 = out_log[base+1];
      checkOutput("b2b_w0_user", w0.user, 128'h11);
      checkOutput("b2b_w1_user", w1.user, 128'h22);
      checkOutput("b2b_w0_last", w0.last, 1);
      checkOutput("b2b_w1_last", w1.last, 1);
      checkOutput("b2b_w1_strb", w1.strb, 32'h000000FF);
    end

    // Reset mid-packet
    applyStimulus(64'h1234, 8'hFF, 128'h33, 1'b0, t);
    applyStimulus(64'h5678, 8'hFF, 128'h33, 1'b0, t);
    axi_resetn = 1'b0;
    #1;
    checkOutput("midrst_tvalid", m_if.tvalid, 0);
    checkOutput("midrst_tdata", m_if.tdata, 0);
    checkOutput("midrst_tstrb", m_if.tstrb, 0);
    checkOutput("midrst_tuser", m_if.tuser, 0);
    repeat (2) @(posedge axi_aclk);
    #1;
    axi_resetn = 1'b1;
    idle(1);
    base = out_log.size();
    for (int k = 1; k <= 3; k++) applyStimulus(64'hA0 + 64'(k), 8'hFF, 128'h77, k == 3, t);
    waitDrain();
    checkOutput("postrst_words", out_log.size() - base, 1);
    if (out_log.size() >= base + 1) begin
      w0 = out_log[base];
      checkOutput("postrst_user", w0.user, 128'h77);
      checkOutput("postrst_strb", w0.strb, 32'h00FFFFFF);
      checkOutput("postrst_lane0", w0.data[63:0], 64'hA1);
    end

    // Randomized packets with random gaps and downstream backpressure
    ready_mode = 1;
    for (int p = 0; p < 150; p++) begin
      int n;
      logic [127:0] u;
      n = $urandom_range(1, 12);
      u = {$urandom, $urandom, $urandom, $urandom};
      for (int k = 0; k < n; k++) begin
        applyStimulus({$urandom, $urandom}, 8'($urandom), (k == 0) ? u : {$urandom, $urandom, $urandom, $urandom},
                      k == n - 1, t);
        idle($urandom_range(0, 2) == 0 ? $urandom_range(1, 3) : 0);
      end
    end
    ready_mode = 0;
    idle(1);
    waitDrain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
